// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter and the
// "1101" sequence-detector benches it feeds.
package seq_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  // The pattern the companion Moore detector looks for.
  localparam logic [3:0] DETECT_PATTERN = 4'b1101;

endpackage : seq_tx_pkg

// File: rtl/seq_pattern_tx_flex_counter.sv
// Parameterised up-counter that wraps from ROLLOVER_VAL-1 to 0. The rollover
// flag is high while the count sits on its terminal value.
module flex_counter #(
  parameter int ROLLOVER_VAL = 4,
  parameter int WIDTH        = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count_enable,
  output logic o_rollover_flag
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max        = (r_count == WIDTH'(ROLLOVER_VAL - 1));
  assign o_rollover_flag = w_at_max;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_count_enable) begin
      r_count <= w_at_max ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule : flex_counter

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first on `o`,
// holding each bit BIT_CYCLES cycles, repeated `reps` times back-to-back.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int   PATTERN_BITS = 4,
  parameter int   REP_W        = 4,
  parameter int   BIT_CYCLES   = 1,
  parameter logic IDLE_VALUE   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [PATTERN_BITS-1:0] pattern,
  input  logic [REP_W-1:0]        reps,
  output logic                    o,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = $clog2(BIT_CYCLES) + 1;
  localparam int IDX_W = $clog2(PATTERN_BITS);

  tx_state_t               r_state;
  logic [PATTERN_BITS-1:0] r_pattern;
  logic [PATTERN_BITS-1:0] r_shift;   // bits still to send, left-aligned
  logic [REP_W-1:0]        r_reps;
  logic                    r_o;
  logic                    r_busy;
  logic                    r_done;

  logic w_load;
  logic w_in_shift;
  logic w_bit_end;
  logic w_pattern_end;

  assign w_in_shift = (r_state == SHIFT);
  assign w_load     = (r_state == IDLE) && start && (reps != '0);

  flex_counter #(
    .ROLLOVER_VAL (BIT_CYCLES),
    .WIDTH        (CNT_W)
  ) u_cycle_cnt (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (w_load),
    .i_count_enable  (w_in_shift),
    .o_rollover_flag (w_bit_end)
  );

  flex_counter #(
    .ROLLOVER_VAL (PATTERN_BITS),
    .WIDTH        (IDX_W)
  ) u_bit_idx (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (w_load),
    .i_count_enable  (w_in_shift && w_bit_end),
    .o_rollover_flag (w_pattern_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pattern <= '0;
      r_shift   <= '0;
      r_reps    <= '0;
      r_o       <= IDLE_VALUE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (reps != '0) begin
              r_pattern <= pattern;
              r_shift   <= {pattern[PATTERN_BITS-2:0], 1'b0};
              r_reps    <= reps;
              r_o       <= pattern[PATTERN_BITS-1];
              r_busy    <= 1'b1;
              r_state   <= SHIFT;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (w_bit_end) begin
            if (!w_pattern_end) begin
              r_o     <= r_shift[PATTERN_BITS-1];
              r_shift <= {r_shift[PATTERN_BITS-2:0], 1'b0};
            end else if (r_reps != REP_W'(1)) begin
              // Restart from the latched copy with no idle gap.
              r_reps  <= r_reps - REP_W'(1);
              r_o     <= r_pattern[PATTERN_BITS-1];
              r_shift <= {r_pattern[PATTERN_BITS-2:0], 1'b0};
            end else begin
              r_o     <= IDLE_VALUE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o    = r_o;
  assign busy = r_busy;
  assign done = r_done;

endmodule : seq_pattern_tx
